// File: rtl/tnoc_adaptive_route_selector_pkg.sv
// ---------------------------------------------------------------------------
// tnoc_adaptive_route_selector_pkg
// Shared definitions for the router's route-selection logic:
//   - output port indices (X+, X-, Y+, Y-, LOCAL) and port count
//   - one-hot route encoding (route_t plus named constants)
//   - routing mode encoding (route_mode_t)
// No ports; imported by tnoc_route_channel and tnoc_adaptive_route_selector.
// ---------------------------------------------------------------------------
package tnoc_adaptive_route_selector_pkg;

    localparam int PORTS      = 5;
    localparam int PORT_XP    = 0;
    localparam int PORT_XM    = 1;
    localparam int PORT_YP    = 2;
    localparam int PORT_YM    = 3;
    localparam int PORT_LOCAL = 4;

    // Routable mesh directions, i.e. every port except LOCAL.
    localparam int MESH_PORTS = 4;

    typedef logic [PORTS-1:0] route_t;

    localparam route_t ROUTE_NONE  = 5'b00000;
    localparam route_t ROUTE_XP    = 5'b00001;
    localparam route_t ROUTE_XM    = 5'b00010;
    localparam route_t ROUTE_YP    = 5'b00100;
    localparam route_t ROUTE_YM    = 5'b01000;
    localparam route_t ROUTE_LOCAL = 5'b10000;

    typedef enum logic [1:0] {
        MODE_XY       = 2'd0,
        MODE_YX       = 2'd1,
        MODE_ADAPTIVE = 2'd2,
        MODE_RESERVED = 2'd3
    } route_mode_t;

endpackage

// File: rtl/tnoc_route_channel.sv
// ---------------------------------------------------------------------------
// tnoc_route_channel
// Route selection for one virtual channel: computes the output port of a
// head flit, latches it for the rest of the packet and tracks the packet
// with a two-state IDLE/ACTIVE FSM.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_valid/head/tail/accept  flit handshake of this VC
//   i_dest_x/i_dest_y head destination coordinates
//   i_mode            routing mode (XY, YX, adaptive, reserved)
//   i_port_credit     free credits of the four mesh ports
//   o_route           one-hot route presented this cycle (zero = none)
//   o_flit_ok         current flit is protocol-legal and may raise requests
//   o_error           sticky protocol/route error
// ---------------------------------------------------------------------------
module tnoc_route_channel
    import tnoc_adaptive_route_selector_pkg::*;
#(
    parameter int           X               = 0,
    parameter int           Y               = 0,
    parameter int           ID_X_WIDTH      = 3,
    parameter int           ID_Y_WIDTH      = 3,
    parameter logic [4:0]   AVAILABLE_PORTS = 5'b11111,
    parameter int           CREDIT_WIDTH    = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       i_valid,
    input  logic                                       i_head,
    input  logic                                       i_tail,
    input  logic                                       i_accept,
    input  logic [ID_X_WIDTH-1:0]                      i_dest_x,
    input  logic [ID_Y_WIDTH-1:0]                      i_dest_y,
    input  logic [1:0]                                 i_mode,
    input  logic [MESH_PORTS-1:0][CREDIT_WIDTH-1:0]    i_port_credit,
    output route_t                                     o_route,
    output logic                                       o_flit_ok,
    output logic                                       o_error
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [ID_X_WIDTH-1:0] X_POS = ID_X_WIDTH'(X);
    localparam logic [ID_Y_WIDTH-1:0] Y_POS = ID_Y_WIDTH'(Y);

    // ---------------------------------------------------------------
    // Productive directions, restricted to ports this router has.
    // ---------------------------------------------------------------
    logic want_xp, want_xm, want_yp, want_ym, at_local;

    assign want_xp  = (i_dest_x > X_POS) && AVAILABLE_PORTS[PORT_XP];
    assign want_xm  = (i_dest_x < X_POS) && AVAILABLE_PORTS[PORT_XM];
    assign want_yp  = (i_dest_y > Y_POS) && AVAILABLE_PORTS[PORT_YP];
    assign want_ym  = (i_dest_y < Y_POS) && AVAILABLE_PORTS[PORT_YM];
    assign at_local = (i_dest_x == X_POS) && (i_dest_y == Y_POS);

    route_t                  x_pick, y_pick, calc_route;
    logic [CREDIT_WIDTH-1:0] x_credit, y_credit;
    logic                    calc_err;

    // NOTE: every signal assigned in an always_comb gets a default on the
    // first lines, so no path through the if/case leaves it holding its old
    // value and no latch is inferred.
    always_comb begin
        calc_route = ROUTE_NONE;
        calc_err   = 1'b0;
        // At most one X and one Y direction can be productive at a time.
        x_pick     = want_xp ? ROUTE_XP : (want_xm ? ROUTE_XM : ROUTE_NONE);
        y_pick     = want_yp ? ROUTE_YP : (want_ym ? ROUTE_YM : ROUTE_NONE);
        x_credit   = want_xp ? i_port_credit[PORT_XP] : i_port_credit[PORT_XM];
        y_credit   = want_yp ? i_port_credit[PORT_YP] : i_port_credit[PORT_YM];

        if (route_mode_t'(i_mode) == MODE_RESERVED) begin
            calc_err = 1'b1;
        end else if (at_local) begin
            if (AVAILABLE_PORTS[PORT_LOCAL]) calc_route = ROUTE_LOCAL;
            else                             calc_err   = 1'b1;
        end else if ((x_pick == ROUTE_NONE) && (y_pick == ROUTE_NONE)) begin
            // Destination lies only in directions this router lacks.
            calc_err = 1'b1;
        end else begin
            case (route_mode_t'(i_mode))
                MODE_XY: calc_route = (x_pick != ROUTE_NONE) ? x_pick : y_pick;
                MODE_YX: calc_route = (y_pick != ROUTE_NONE) ? y_pick : x_pick;
                default: begin
                    // Adaptive: Y only wins with strictly more credit.
                    if (x_pick == ROUTE_NONE)      calc_route = y_pick;
                    else if (y_pick == ROUTE_NONE) calc_route = x_pick;
                    else                           calc_route = (y_credit > x_credit) ? y_pick : x_pick;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Packet FSM and route latch
    // ---------------------------------------------------------------
    logic [0:0] state_q, state_d;
    route_t     route_q, route_d;
    logic       error_q, error_d;

    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        error_d   = error_q;
        o_route   = ROUTE_NONE;
        o_flit_ok = 1'b0;

        if (state_q == ST_IDLE) begin
            if (i_valid && i_head) begin
                // Zero-latency: the head is routed in the cycle it appears.
                o_route   = calc_route;
                o_flit_ok = 1'b1;
                route_d   = calc_route;
                error_d   = error_q | calc_err;
                if (!(i_accept && i_tail)) state_d = ST_ACTIVE;
            end else if (i_valid) begin
                // Body/tail with no packet open.
                error_d = 1'b1;
            end
        end else begin
            // Route held for the whole packet, whatever credits do.
            o_route = route_q;
            if (i_valid && i_head) begin
                // Head inside an open packet: flag it, keep the packet.
                error_d = 1'b1;
            end else if (i_valid) begin
                o_flit_ok = 1'b1;
                if (i_accept && i_tail) state_d = ST_IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            route_q <= ROUTE_NONE;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            error_q <= error_d;
        end
    end

    assign o_error = error_q;

endmodule

// File: rtl/tnoc_adaptive_route_selector.sv
// ---------------------------------------------------------------------------
// tnoc_adaptive_route_selector
// Per-router route selection for all virtual channels. One tnoc_route_channel
// per VC picks and holds a route; this level transposes the per-VC routes
// into per-port request/SOP/EOP vectors for the output arbiters and counts
// completed packets per output port (saturating).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   i_valid/head/tail/accept  per-VC flit handshake
//   i_dest_x/i_dest_y     per-VC head destination
//   i_mode                per-VC routing mode
//   i_port_credit         free credits per output port
//   o_route               per-VC one-hot route (zero = none)
//   o_request, o_start_of_packet, o_end_of_packet  per-port, per-VC controls
//   o_error               per-VC sticky error
//   o_packet_count        packets routed per output port
// ---------------------------------------------------------------------------
module tnoc_adaptive_route_selector
    import tnoc_adaptive_route_selector_pkg::*;
#(
    parameter int           CHANNELS        = 2,
    parameter int           X               = 0,
    parameter int           Y               = 0,
    parameter int           ID_X_WIDTH      = 3,
    parameter int           ID_Y_WIDTH      = 3,
    parameter logic [4:0]   AVAILABLE_PORTS = 5'b11111,
    parameter int           CREDIT_WIDTH    = 4,
    parameter int           COUNT_WIDTH     = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [CHANNELS-1:0]                     i_valid,
    input  logic [CHANNELS-1:0]                     i_head,
    input  logic [CHANNELS-1:0]                     i_tail,
    input  logic [CHANNELS-1:0]                     i_accept,
    input  logic [CHANNELS-1:0][ID_X_WIDTH-1:0]     i_dest_x,
    input  logic [CHANNELS-1:0][ID_Y_WIDTH-1:0]     i_dest_y,
    input  logic [CHANNELS-1:0][1:0]                i_mode,
    input  logic [PORTS-1:0][CREDIT_WIDTH-1:0]      i_port_credit,
    output logic [CHANNELS-1:0][PORTS-1:0]          o_route,
    output logic [PORTS-1:0][CHANNELS-1:0]          o_request,
    output logic [PORTS-1:0][CHANNELS-1:0]          o_start_of_packet,
    output logic [PORTS-1:0][CHANNELS-1:0]          o_end_of_packet,
    output logic [CHANNELS-1:0]                     o_error,
    output logic [PORTS-1:0][COUNT_WIDTH-1:0]       o_packet_count
);

    localparam int SUM_W   = $clog2(CHANNELS + 1);
    localparam int TOTAL_W = COUNT_WIDTH + SUM_W;

    // Ejection into the local core never competes for credits, so the
    // LOCAL credit plays no part in route choice.
    logic unused_local_credit;
    assign unused_local_credit = ^i_port_credit[PORT_LOCAL];

    route_t [CHANNELS-1:0] chan_route;
    logic   [CHANNELS-1:0] chan_ok;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        tnoc_route_channel #(
            .X               (X),
            .Y               (Y),
            .ID_X_WIDTH      (ID_X_WIDTH),
            .ID_Y_WIDTH      (ID_Y_WIDTH),
            .AVAILABLE_PORTS (AVAILABLE_PORTS),
            .CREDIT_WIDTH    (CREDIT_WIDTH)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .i_valid       (i_valid[c]),
            .i_head        (i_head[c]),
            .i_tail        (i_tail[c]),
            .i_accept      (i_accept[c]),
            .i_dest_x      (i_dest_x[c]),
            .i_dest_y      (i_dest_y[c]),
            .i_mode        (i_mode[c]),
            .i_port_credit (i_port_credit[MESH_PORTS-1:0]),
            .o_route       (chan_route[c]),
            .o_flit_ok     (chan_ok[c]),
            .o_error       (o_error[c])
        );
    end

    // Transpose VC-major routes into port-major arbiter controls. Masking
    // with AVAILABLE_PORTS pins every disabled port's outputs to zero.
    always_comb begin
        o_route           = '0;
        o_request         = '0;
        o_start_of_packet = '0;
        o_end_of_packet   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            o_route[c] = chan_route[c] & AVAILABLE_PORTS;
            for (int p = 0; p < PORTS; p++) begin
                if (AVAILABLE_PORTS[p] && chan_route[c][p] && i_valid[c] && chan_ok[c]) begin
                    o_request[p][c]         = 1'b1;
                    o_start_of_packet[p][c] = i_head[c];
                    o_end_of_packet[p][c]   = i_accept[c] & i_tail[c];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Per-port saturating packet counters
    // ---------------------------------------------------------------
    for (genvar p = 0; p < PORTS; p++) begin : g_cnt
        if (AVAILABLE_PORTS[p]) begin : g_on
            logic [COUNT_WIDTH-1:0] count_q, count_d;
            logic [SUM_W-1:0]       ends;
            logic [TOTAL_W-1:0]     total;
            logic [TOTAL_W-1:0]     limit;

            assign limit = {{SUM_W{1'b0}}, {COUNT_WIDTH{1'b1}}};

            always_comb begin
                // Several VCs may finish on this port in the same cycle.
                ends = '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    ends = ends + SUM_W'(o_end_of_packet[p][c]);
                end
                total   = TOTAL_W'(count_q) + TOTAL_W'(ends);
                count_d = (total > limit) ? {COUNT_WIDTH{1'b1}} : total[COUNT_WIDTH-1:0];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) count_q <= '0;
                else     count_q <= count_d;
            end

            assign o_packet_count[p] = count_q;
        end else begin : g_off
            assign o_packet_count[p] = '0;
        end
    end

endmodule

// File: tb/tb_tnoc_adaptive_route_selector.sv
// ---------------------------------------------------------------------------
// tb_tnoc_adaptive_route_selector
// Scoreboard bench. Main DUT: router (1,1), 2 VCs, all ports, 4-bit counters.
// Second DUT: same router with LOCAL disabled.
// The stimulus side computes each cycle's expected outputs from a packet-level
// reference model and queues them; a monitor on the falling edge pops and
// compares against the DUT.
// ---------------------------------------------------------------------------
module tb_tnoc_adaptive_route_selector;

    localparam int CH = 2;
    localparam int CW = 4;
    localparam int NW = 4;
    localparam int TX = 1;
    localparam int TY = 1;
    localparam int CNT_MAX = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main DUT signals
    logic [CH-1:0]         valid, head, tail, accept;
    logic [CH-1:0][2:0]    dest_x, dest_y;
    logic [CH-1:0][1:0]    mode;
    logic [4:0][CW-1:0]    credit;
    logic [CH-1:0][4:0]    route;
    logic [4:0][CH-1:0]    req, sop, eop;
    logic [CH-1:0]         err;
    logic [4:0][NW-1:0]    cnt;

    // Second DUT (LOCAL disabled)
    logic [CH-1:0]         b_valid, b_head, b_tail, b_accept;
    logic [CH-1:0][2:0]    b_dest_x, b_dest_y;
    logic [CH-1:0][1:0]    b_mode;
    logic [4:0][CW-1:0]    b_credit;
    logic [CH-1:0][4:0]    b_route;
    logic [4:0][CH-1:0]    b_req, b_sop, b_eop;
    logic [CH-1:0]         b_err;
    logic [4:0][NW-1:0]    b_cnt;

    tnoc_adaptive_route_selector #(
        .CHANNELS(CH), .X(TX), .Y(TY), .ID_X_WIDTH(3), .ID_Y_WIDTH(3),
        .AVAILABLE_PORTS(5'b11111), .CREDIT_WIDTH(CW), .COUNT_WIDTH(NW)
    ) u_dut (
        .clk(clk), .rst(rst),
        .i_valid(valid), .i_head(head), .i_tail(tail), .i_accept(accept),
        .i_dest_x(dest_x), .i_dest_y(dest_y), .i_mode(mode),
        .i_port_credit(credit),
        .o_route(route), .o_request(req), .o_start_of_packet(sop),
        .o_end_of_packet(eop), .o_error(err), .o_packet_count(cnt)
    );

    tnoc_adaptive_route_selector #(
        .CHANNELS(CH), .X(TX), .Y(TY), .ID_X_WIDTH(3), .ID_Y_WIDTH(3),
        .AVAILABLE_PORTS(5'b01111), .CREDIT_WIDTH(CW), .COUNT_WIDTH(NW)
    ) u_dut_nolocal (
        .clk(clk), .rst(rst),
        .i_valid(b_valid), .i_head(b_head), .i_tail(b_tail), .i_accept(b_accept),
        .i_dest_x(b_dest_x), .i_dest_y(b_dest_y), .i_mode(b_mode),
        .i_port_credit(b_credit),
        .o_route(b_route), .o_request(b_req), .o_start_of_packet(b_sop),
        .o_end_of_packet(b_eop), .o_error(b_err), .o_packet_count(b_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: packet-level view per VC
    // ---------------------------------------------------------------
    typedef struct packed {
        logic [CH-1:0][4:0] route;
        logic [4:0][CH-1:0] req;
        logic [4:0][CH-1:0] sop;
        logic [4:0][CH-1:0] eop;
        logic [CH-1:0]      err;
        logic [4:0][NW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    bit m_active [CH];
    int m_port   [CH];
    bit m_err    [CH];
    int m_cnt    [5];

    // Port choice from the routing rules, -1 for a routing error.
    function automatic int ref_route(int c);
        int dx, dy, md, px, py;
        dx = int'(dest_x[c]);
        dy = int'(dest_y[c]);
        md = int'(mode[c]);
        if (md == 3) return -1;
        if (dx == TX && dy == TY) return 4;
        px = (dx > TX) ? 0 : ((dx < TX) ? 1 : -1);
        py = (dy > TY) ? 2 : ((dy < TY) ? 3 : -1);
        if (px < 0 && py < 0) return -1;
        if (md == 0) return (px >= 0) ? px : py;
        if (md == 1) return (py >= 0) ? py : px;
        if (px < 0) return py;
        if (py < 0) return px;
        return (credit[py] > credit[px]) ? py : px;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            m_active[c] = 0; m_port[c] = -1; m_err[c] = 0;
        end
        for (int p = 0; p < 5; p++) m_cnt[p] = 0;
    endtask

    // Queue this cycle's expectation, then advance one clock.
    task automatic cycle();
        exp_t e;
        bit   n_active [CH];
        int   n_port   [CH];
        bit   n_err    [CH];
        int   n_cnt    [5];
        if (rst) model_clear();
        e = '0;
        for (int p = 0; p < 5; p++) begin
            n_cnt[p] = m_cnt[p];
            e.cnt[p] = NW'(m_cnt[p]);
        end
        for (int c = 0; c < CH; c++) begin
            int cur;
            bit ok;
            n_active[c] = m_active[c];
            n_port[c]   = m_port[c];
            n_err[c]    = m_err[c];
            e.err[c]    = m_err[c];
            cur = -1;
            if (m_active[c]) begin
                cur = m_port[c];
                ok  = valid[c] && !head[c];
            end else begin
                ok = valid[c] && head[c];
                if (ok) cur = ref_route(c);
            end
            if (cur >= 0) e.route[c][cur] = 1'b1;
            if (ok && cur >= 0) begin
                e.req[cur][c] = 1'b1;
                e.sop[cur][c] = head[c];
                if (accept[c] && tail[c]) begin
                    e.eop[cur][c] = 1'b1;
                    if (n_cnt[cur] < CNT_MAX) n_cnt[cur]++;
                end
            end
            if (valid[c] && !ok) n_err[c] = 1;
            if (!m_active[c] && ok) begin
                if (cur < 0) n_err[c] = 1;
                n_port[c]   = cur;
                n_active[c] = !(accept[c] && tail[c]);
            end else if (m_active[c] && ok && accept[c] && tail[c]) begin
                n_active[c] = 0;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            model_clear();
        end else begin
            for (int c = 0; c < CH; c++) begin
                m_active[c] = n_active[c]; m_port[c] = n_port[c]; m_err[c] = n_err[c];
            end
            for (int p = 0; p < 5; p++) m_cnt[p] = n_cnt[p];
        end
    endtask

    // Monitor: compare on the falling edge whenever an expectation is queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_route", 64'(route), 64'(e.route));
                check("sb_request", 64'(req), 64'(e.req));
                check("sb_sop", 64'(sop), 64'(e.sop));
                check("sb_eop", 64'(eop), 64'(e.eop));
                check("sb_error", 64'(err), 64'(e.err));
                check("sb_count", 64'(cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    task automatic idle_all();
        valid = '0; head = '0; tail = '0; accept = '0;
    endtask

    task automatic drive(input int c, input bit v, input bit h, input bit t, input bit a,
                         input int dx, input int dy, input int md);
        valid[c] = v; head[c] = h; tail[c] = t; accept[c] = a;
        dest_x[c] = 3'(dx); dest_y[c] = 3'(dy); mode[c] = 2'(md);
    endtask

    int       left    [CH];
    bit       started [CH];
    bit [2:0] sx      [CH];
    bit [2:0] sy      [CH];
    bit [1:0] sm      [CH];

    initial begin
        rst = 1'b1;
        idle_all();
        dest_x = '0; dest_y = '0; mode = '0; credit = '0;
        b_valid = '0; b_head = '0; b_tail = '0; b_accept = '0;
        b_dest_x = '0; b_dest_y = '0; b_mode = '0; b_credit = '0;
        model_clear();
        @(posedge clk); #1;

        // Reset state
        check("reset_route", 64'(route), 64'd0);
        check("reset_count", 64'(cnt), 64'd0);
        check("reset_error", 64'(err), 64'd0);
        cycle();
        rst = 1'b0;
        cycle();

        // XY: head to (3,0) in mode 0 -> X+, held for 4 flits
        drive(0, 1, 1, 0, 1, 3, 0, 0); #1;
        check("xy_head_route", 64'(route[0]), 64'(5'b00001));
        cycle();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 1, 3, 0, 0); #1;
            check("xy_body_route", 64'(route[0]), 64'(5'b00001));
            cycle();
        end
        drive(0, 1, 0, 1, 1, 3, 0, 0); #1;
        check("xy_tail_eop", 64'(eop[0][0]), 64'd1);
        cycle();
        idle_all(); #1;
        check("xy_idle_route", 64'(route[0]), 64'd0);
        check("xy_count", 64'(cnt[0]), 64'd1);
        cycle();

        // Adaptive: (3,3), X+=2 / Y+=5 -> Y+, swap mid-packet keeps Y+
        credit[0] = 4'd2; credit[2] = 4'd5;
        drive(0, 1, 1, 0, 1, 3, 3, 2); #1;
        check("adapt_head_route", 64'(route[0]), 64'(5'b00100));
        cycle();
        credit[0] = 4'd5; credit[2] = 4'd2;
        drive(0, 1, 0, 0, 1, 3, 3, 2); #1;
        check("adapt_hold_route", 64'(route[0]), 64'(5'b00100));
        cycle();
        drive(0, 1, 0, 1, 1, 3, 3, 2);
        cycle();
        credit[0] = 4'd3; credit[2] = 4'd3;
        drive(0, 1, 1, 1, 1, 3, 3, 2); #1;
        check("adapt_tie_route", 64'(route[0]), 64'(5'b00001));
        cycle();
        idle_all(); #1;
        check("adapt_count_yp", 64'(cnt[2]), 64'd1);
        check("adapt_count_xp", 64'(cnt[0]), 64'd2);
        cycle();

        // Single-flit packet to LOCAL on VC1, accepted in the head cycle
        drive(1, 1, 1, 1, 1, 1, 1, 0); #1;
        check("single_route", 64'(route[1]), 64'(5'b10000));
        check("single_eop", 64'(eop[4]), 64'(2'b10));
        cycle();
        idle_all(); #1;
        check("single_idle", 64'(route[1]), 64'd0);
        check("single_count", 64'(cnt[4]), 64'd1);
        cycle();

        // Two VCs ending on LOCAL in the same cycle -> +2
        drive(0, 1, 1, 1, 1, 1, 1, 0);
        drive(1, 1, 1, 1, 1, 1, 1, 1); #1;
        check("dual_eop", 64'(eop[4]), 64'(2'b11));
        cycle();
        idle_all(); #1;
        check("dual_count", 64'(cnt[4]), 64'd3);
        cycle();

        // Saturation: 17 more LOCAL packets
        for (int i = 0; i < 17; i++) begin
            drive(0, 1, 1, 1, 1, 1, 1, 0);
            cycle();
        end
        idle_all(); #1;
        check("sat_count", 64'(cnt[4]), 64'(CNT_MAX));
        cycle();

        // Body flit in IDLE on VC1 -> no request, sticky error
        drive(1, 1, 0, 1, 1, 3, 1, 0); #1;
        check("body_idle_req", 64'(req), 64'd0);
        cycle();
        idle_all(); #1;
        check("body_idle_err", 64'(err), 64'(2'b10));
        cycle();

        // Reset mid-packet on VC1
        drive(1, 1, 1, 0, 1, 0, 1, 0); #1;
        check("mid_head_route", 64'(route[1]), 64'(5'b00010));
        cycle();
        drive(1, 1, 0, 0, 0, 0, 1, 0);
        cycle();
        idle_all();
        rst = 1'b1; #1;
        check("mid_rst_route", 64'(route), 64'd0);
        check("mid_rst_count", 64'(cnt), 64'd0);
        check("mid_rst_error", 64'(err), 64'd0);
        cycle();
        rst = 1'b0;
        drive(1, 1, 1, 0, 1, 1, 2, 0); #1;
        check("post_rst_route", 64'(route[1]), 64'(5'b00100));
        cycle();
        drive(1, 1, 0, 1, 1, 1, 2, 0);
        cycle();
        idle_all();
        cycle();

        // Randomized traffic with occasional protocol violations
        for (int c = 0; c < CH; c++) begin
            left[c] = 0; started[c] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 499) begin
                idle_all();
                rst = 1'b1;
                cycle();
                rst = 1'b0;
                for (int c = 0; c < CH; c++) begin
                    left[c] = 0; started[c] = 0;
                end
                continue;
            end
            for (int p = 0; p < 5; p++) credit[p] = CW'($urandom_range(0, 15));
            for (int c = 0; c < CH; c++) begin
                bit bad;
                if (left[c] == 0) begin
                    left[c]    = $urandom_range(1, 4);
                    started[c] = 0;
                    sx[c] = 3'($urandom_range(0, 7));
                    sy[c] = 3'($urandom_range(0, 7));
                    sm[c] = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                end
                bad       = ($urandom_range(0, 99) < 3);
                valid[c]  = ($urandom_range(0, 99) < 70);
                head[c]   = !started[c];
                tail[c]   = (left[c] == 1);
                accept[c] = valid[c] && (head[c] || ($urandom_range(0, 99) < 60));
                dest_x[c] = sx[c]; dest_y[c] = sy[c]; mode[c] = sm[c];
                if (bad && valid[c]) begin
                    head[c]   = ~head[c];
                    accept[c] = 1'b0;
                end
                if (valid[c] && accept[c]) begin
                    started[c] = 1;
                    left[c]--;
                end
            end
            cycle();
        end
        idle_all();
        cycle();

        // LOCAL disabled: local destination is an error with no route
        b_valid[0] = 1'b1; b_head[0] = 1'b1; b_tail[0] = 1'b1; b_accept[0] = 1'b1;
        b_dest_x[0] = 3'd1; b_dest_y[0] = 3'd1; b_mode[0] = 2'd0; #1;
        check("nolocal_route", 64'(b_route), 64'd0);
        check("nolocal_req", 64'(b_req), 64'd0);
        cycle();
        b_dest_x[0] = 3'd3; #1;
        check("nolocal_err", 64'(b_err), 64'(2'b01));
        check("nolocal_xp_route", 64'(b_route[0]), 64'(5'b00001));
        cycle();
        b_valid = '0; b_head = '0; b_tail = '0; b_accept = '0; #1;
        check("nolocal_count_xp", 64'(b_cnt[0]), 64'd1);
        check("nolocal_count_local", 64'(b_cnt[4]), 64'd0);
        cycle();

        repeat (2) @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tnoc_adaptive_route_selector.md
TNOC_ADAPTIVE_ROUTE_SELECTOR -- requirements
Module: tnoc_adaptive_route_selector

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: virtual channels (1..8).
REQ-002 SHALL have parameter X, default 0: router x coordinate.
REQ-003 SHALL have parameter Y, default 0: router y coordinate.
REQ-004 SHALL have parameter ID_X_WIDTH, default 3: destination x width.
REQ-005 SHALL have parameter ID_Y_WIDTH, default 3: destination y width.
REQ-006 SHALL have parameter AVAILABLE_PORTS, default 5'b11111: enabled output ports; bit order X+, X-, Y+, Y-, LOCAL.
REQ-007 SHALL have parameter CREDIT_WIDTH, default 4: width of per-port credit count.
REQ-008 SHALL have parameter COUNT_WIDTH, default 16: width of per-port packet counters.
REQ-009 SHALL have clk  input  1  clock; single clock domain.
REQ-010 SHALL have rst  input  1  reset; asynchronous, active-high.
REQ-011 SHALL have i_valid  input  CHANNELS  flit present per VC.
REQ-012 SHALL have i_head  input  CHANNELS  flit is head.
REQ-013 SHALL have i_tail  input  CHANNELS  flit is tail (head+tail = single-flit packet).
REQ-014 SHALL have i_accept  input  CHANNELS  flit consumed this cycle.
REQ-015 SHALL have i_dest_x, i_dest_y  input  CHANNELS x ID_X_WIDTH / ID_Y_WIDTH  head destination.
REQ-016 SHALL have i_mode  input  CHANNELS x 2  routing mode: 0 XY, 1 YX, 2 adaptive minimal, 3 reserved.
REQ-017 SHALL have i_port_credit  input  5 x CREDIT_WIDTH  free credits per output port.
REQ-018 SHALL have o_route  output  CHANNELS x 5  one-hot route per VC; all-zero = none.
REQ-019 SHALL have o_request, o_start_of_packet, o_end_of_packet  output  5 x CHANNELS  per-port control to arbiters.
REQ-020 SHALL have o_error  output  CHANNELS  sticky protocol/route error.
REQ-021 SHALL have o_packet_count  output  5 x COUNT_WIDTH  packets routed per port.

Function
REQ-022 SHALL keep per-VC FSM IDLE/ACTIVE; IDLE -> ACTIVE on valid&head unless accept&tail in the same cycle; ACTIVE -> IDLE on valid&accept&tail.
REQ-023 SHALL, in IDLE with valid&head, drive o_route combinationally from the current head (zero latency) and latch it into the route register.
REQ-024 SHALL, in ACTIVE, drive o_route from the latched route, unchanged regardless of credit changes, until the tail is accepted.
REQ-025 SHALL compute productive set: X+ if dest_x>X, X- if dest_x<X, Y+ if dest_y>Y, Y- if dest_y<Y, each masked by AVAILABLE_PORTS; LOCAL when dest equals (X,Y).
REQ-026 SHALL pick the first productive port in order X+,X-,Y+,Y- for mode 0 and Y+,Y-,X+,X- for mode 1.
REQ-027 SHALL pick, in mode 2, the productive X or Y port with strictly greater i_port_credit; ties choose X.
REQ-028 SHALL output all-zero route and set o_error for: mode 3; destination off-router while productive set is empty; LOCAL required but disabled.
REQ-029 SHALL set o_error for a non-head valid flit in IDLE or a head flit in ACTIVE; such flits produce no request, and the FSM does not change.
REQ-030 SHALL drive o_request[p][c]=route[c][p]&i_valid[c]; o_start_of_packet=route&valid&head; o_end_of_packet=route&valid&accept&tail.
REQ-031 SHALL increment o_packet_count[p] by one per o_end_of_packet pulse on p, summing simultaneous pulses from multiple VCs, saturating at all-ones.
REQ-032 SHALL tie all outputs of disabled ports to zero.

Reset
REQ-033 SHALL, while rst is high, force FSMs to IDLE, latched routes to zero, o_error to zero, and counters to zero, asynchronously.
REQ-034 SHALL abandon any in-flight packet on reset mid-packet; the first flit after reset must be a head.

Structure
REQ-035 SHALL place route one-hot encoding, port index constants and mode encoding in the shared tnoc package.
REQ-036 SHALL instantiate one sub-module per VC, tnoc_route_channel (FSM, route computation, latch); counters and the port transpose stay in the top.

Verification
REQ-037 SHALL check XY: X=1,Y=1, head dest (3,0), mode 0 -> o_route=X+ same cycle; held through 4-flit packet; IDLE after tail accept.
REQ-038 SHALL check adaptive: dest (3,3), credits X+=2,Y+=5 -> Y+; credits then swapped mid-packet -> route stays Y+; tie 3/3 -> X+.
REQ-039 SHALL check single-flit packet with accept in the head cycle -> o_end_of_packet pulse, FSM remains IDLE, o_packet_count increments by 1.
REQ-040 SHALL check errors: body flit in IDLE -> o_error=1, no request; AVAILABLE_PORTS=5'b01111 with local dest -> o_error=1.
REQ-041 SHALL check reset asserted mid-packet on VC1 -> o_route=0, counters=0, next head routed normally.
REQ-042 SHALL check counter saturation: COUNT_WIDTH=4, 17 packets to LOCAL -> count holds at 15; two VCs ending on the same port in one cycle -> +2.
